// File: rtl/vigna_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vigna_bus_pkg
//  Purpose  : Shared types and constants for the vigna bus arbiter slice:
//             FSM state encoding, grant identifiers and strobe width helper.
//  Revision : 1.0 - initial release
// ============================================================================
package vigna_bus_pkg;

   // Default bus widths; the arbiter itself is parameterised independently.
   localparam int VIGNA_BUS_DATA_W = 32;
   localparam int VIGNA_BUS_STRB_W = VIGNA_BUS_DATA_W / 8;

   // Arbiter FSM encoding: one idle state and one busy state per master.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_BUSY_I = 2'b01,
      ST_BUSY_D = 2'b10
   } state_t;

   // Grant identifiers, also used as the last-grant history value.
   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Byte-strobe width for an arbitrary data width.
   function automatic int strb_width(input int data_w);
      return data_w / 8;
   endfunction

endpackage : vigna_bus_pkg
`default_nettype wire

// File: rtl/vigna_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module   : vigna_arb_pick
//  Purpose  : Two-request winner select for the vigna bus arbiter.
//             Default build: fixed priority, data port wins over fetch port.
//             VIGNA_BUS_ARBITER_ROUND_ROBIN_EN defined: on a tie the master
//             that was not granted last wins.
//  Revision : 1.0 - initial release
// ============================================================================
module vigna_arb_pick
   import vigna_bus_pkg::*;
(
   input  logic i_req_i,       // fetch port request
   input  logic d_req_i,       // data port request
   input  logic last_grant_i,  // master that completed most recently
   output logic gnt_d_o        // 1: data port wins, 0: fetch port wins
);

`ifdef VIGNA_BUS_ARBITER_ROUND_ROBIN_EN
   // Tie goes to the master other than the last one served; lone requester wins.
   always_comb begin
      gnt_d_o = d_req_i;
      if (i_req_i && d_req_i) begin
         gnt_d_o = (last_grant_i == GNT_I);
      end
   end
`else
   // History is irrelevant for fixed priority.
   logic unused_last_grant;
   assign unused_last_grant = last_grant_i;

   // Data port always wins when it requests; otherwise the fetch port does.
   always_comb begin
      gnt_d_o = d_req_i;
      if (!d_req_i && !i_req_i) begin
         gnt_d_o = 1'b0;
      end
   end
`endif

endmodule : vigna_arb_pick
`default_nettype wire

// File: rtl/vigna_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vigna_bus_arbiter
//  Purpose  : Shares one valid/ready memory port between the core's fetch
//             (i_*) and data (d_*) ports, one transaction at a time.
//             Optional macro VIGNA_BUS_ARBITER_ROUND_ROBIN_EN switches the
//             tie-break from fixed data-first to round-robin.
//  Revision : 1.0 - initial release
// ============================================================================
module vigna_bus_arbiter
   import vigna_bus_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   // Fetch port
   input  logic                    i_valid,
   output logic                    i_ready,
   input  logic [ADDR_WIDTH-1:0]   i_addr,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   // Data port
   input  logic                    d_valid,
   output logic                    d_ready,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_wstrb,
   // Memory port
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [ADDR_WIDTH-1:0]   m_addr,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   output logic [DATA_WIDTH/8-1:0] m_wstrb
);

   state_t state_q;
   logic   m_valid_q;
   logic   last_grant_q;
   logic   gnt_d_w;
   logic   busy_i_w;
   logic   busy_d_w;

   // Winner select for requests seen in IDLE.
   vigna_arb_pick u_pick (
      .i_req_i      (i_valid),
      .d_req_i      (d_valid),
      .last_grant_i (last_grant_q),
      .gnt_d_o      (gnt_d_w)
   );

   // Arbiter FSM: grant in IDLE, hold until m_ready, then one forced IDLE cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         m_valid_q    <= 1'b0;
         last_grant_q <= GNT_I;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid || d_valid) begin
                  state_q   <= gnt_d_w ? ST_BUSY_D : ST_BUSY_I;
                  m_valid_q <= 1'b1;
               end
            end
            ST_BUSY_I: begin
               if (m_ready) begin
                  state_q      <= ST_IDLE;
                  m_valid_q    <= 1'b0;
                  last_grant_q <= GNT_I;
               end
            end
            ST_BUSY_D: begin
               if (m_ready) begin
                  state_q      <= ST_IDLE;
                  m_valid_q    <= 1'b0;
                  last_grant_q <= GNT_D;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               m_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy_i_w = (state_q == ST_BUSY_I);
   assign busy_d_w = (state_q == ST_BUSY_D);

   // Completion is forwarded only to the granted master, in the m_ready cycle.
   assign i_ready = busy_i_w && m_ready;
   assign d_ready = busy_d_w && m_ready;

   // Read data is broadcast; the ready strobe tells each master when it is valid.
   assign i_rdata = m_rdata;
   assign d_rdata = m_rdata;

   // Request mux: the fetch port never writes, so its data and strobes are zero.
   assign m_valid = m_valid_q;
   assign m_addr  = busy_d_w ? d_addr  : i_addr;
   assign m_wdata = busy_d_w ? d_wdata : '0;
   assign m_wstrb = busy_d_w ? d_wstrb : '0;

endmodule : vigna_bus_arbiter
`default_nettype wire

// File: tb/tb_vigna_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vigna_bus_arbiter
//  Purpose  : Self-checking bench for vigna_bus_arbiter: directed cases plus
//             randomized request rounds, checked by a scoreboard against a
//             transaction-order reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vigna_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_valid, i_ready;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          d_valid, d_ready;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_rdata, d_wdata;
   logic [SW-1:0] d_wstrb;
   logic          m_valid, m_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_rdata, m_wdata;
   logic [SW-1:0] m_wstrb;

   vigna_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset(reset),
      .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
      .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_rdata(m_rdata),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb)
   );

   always #5 clk = ~clk;

   // Expected transaction as seen on the memory port, in grant order.
   typedef struct packed {
      logic          port;   // 0 = fetch, 1 = data
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] rdata;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   bit   model_last;          // master served most recently (0 = fetch)
   bit   slave_en = 1'b1;
   int   lat_fixed = -1;      // >= 0 forces slave latency, disables stray readies
   int   wait_cnt = 0;

   // Memory contents as a pure function of address.
   function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
      if (a == 32'h0000_0100) return 32'h0000_0013;
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic int pick_lat();
      if (lat_fixed >= 0) return lat_fixed;
      return $urandom_range(0, 3);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Slave: random wait states, read data from mem_fn, occasional stray m_ready in IDLE.
   initial begin
      m_ready = 1'b0;
      m_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (slave_en) begin
            if (m_ready) begin
               m_ready  = 1'b0;
               m_rdata  = $urandom;
               wait_cnt = pick_lat();
            end else if (m_valid) begin
               if (wait_cnt == 0) begin
                  m_ready = 1'b1;
                  m_rdata = mem_fn(m_addr);
               end else begin
                  wait_cnt--;
               end
            end else begin
               wait_cnt = pick_lat();
               if (lat_fixed < 0 && $urandom_range(0, 3) == 0) begin
                  m_ready = 1'b1;
                  m_rdata = $urandom;
               end
            end
         end
      end
   end

   // Monitor: every accepted memory transfer is matched against the scoreboard head.
   exp_t mon_e;
   always @(negedge clk) begin
      if (i_ready && d_ready) begin
         check("both_ready", {i_ready, d_ready}, 2'b00);
      end
      if (m_valid && m_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_xfer", 1'b1, 1'b0);
         end else begin
            mon_e = sb_q.pop_front();
            check("ready_port", {i_ready, d_ready}, mon_e.port ? 2'b01 : 2'b10);
            check("m_addr", m_addr, mon_e.addr);
            check("m_wdata", m_wdata, mon_e.wdata);
            check("m_wstrb", m_wstrb, mon_e.wstrb);
            check("rdata", mon_e.port ? d_rdata : i_rdata, mon_e.rdata);
         end
      end else begin
         check("no_ready_idle", {i_ready, d_ready}, 2'b00);
      end
   end

   // Push expected transfers in model grant order, then raise the requests.
   task automatic issue(input bit ri, input bit rd, input logic [AW-1:0] ia,
                        input logic [AW-1:0] da, input logic [DW-1:0] dw,
                        input logic [SW-1:0] ds);
      exp_t ei, ed;
      bit   first_d;
      ei.port = 1'b0; ei.addr = ia; ei.wdata = '0; ei.wstrb = '0; ei.rdata = mem_fn(ia);
      ed.port = 1'b1; ed.addr = da; ed.wdata = dw; ed.wstrb = ds; ed.rdata = mem_fn(da);
      if (ri && rd) begin
`ifdef VIGNA_BUS_ARBITER_ROUND_ROBIN_EN
         first_d = (model_last == 1'b0);
`else
         first_d = 1'b1;
`endif
         if (first_d) begin
            sb_q.push_back(ed); sb_q.push_back(ei); model_last = 1'b0;
         end else begin
            sb_q.push_back(ei); sb_q.push_back(ed); model_last = 1'b1;
         end
      end else if (ri) begin
         sb_q.push_back(ei); model_last = 1'b0;
      end else if (rd) begin
         sb_q.push_back(ed); model_last = 1'b1;
      end
      i_addr = ia; d_addr = da; d_wdata = dw; d_wstrb = ds;
      i_valid = ri; d_valid = rd;
   endtask

   // Core behaviour: keep valid high until ready, drop it right after.
   task automatic wait_done(input bit ri, input bit rd);
      bit pi, pd, si, sd;
      int cyc;
      pi = ri; pd = rd; cyc = 0;
      while ((pi || pd) && cyc < 100) begin
         @(negedge clk);
         si = i_ready; sd = d_ready;
         @(posedge clk);
         #1;
         if (si && pi) begin pi = 1'b0; i_valid = 1'b0; end
         if (sd && pd) begin pd = 1'b0; d_valid = 1'b0; end
         cyc++;
      end
      check("round_timeout", {pi, pd}, 2'b00);
      i_valid = 1'b0; d_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      int sel;
      model_last = 1'b0;
      reset = 1'b1;
      i_valid = 1'b1; i_addr = 32'h0000_0100;
      d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
      lat_fixed = 2;

      // Reset held with a pending fetch: nothing may leave the arbiter.
      repeat (3) begin
         @(negedge clk);
         check("rst_m_valid", m_valid, 1'b0);
         check("rst_i_ready", i_ready, 1'b0);
         check("rst_d_ready", d_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      issue(1'b1, 1'b0, 32'h0000_0100, '0, '0, '0);
      @(negedge clk);
      check("mvalid_after_rst_n", m_valid, 1'b0);
      @(negedge clk);
      check("mvalid_after_rst_n1", m_valid, 1'b1);
      wait_done(1'b1, 1'b0);

      // Store pass-through.
      lat_fixed = 1;
      issue(1'b0, 1'b1, 32'h0000_0200, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011);
      wait_done(1'b0, 1'b1);

      // Simultaneous requests, then a data-only round followed by two tie rounds.
      lat_fixed = -1;
      issue(1'b1, 1'b1, 32'h0000_0104, 32'h0000_2004, 32'h1234_5678, 4'b1111);
      wait_done(1'b1, 1'b1);
      issue(1'b0, 1'b1, 32'h0000_0108, 32'h0000_2008, 32'h0, 4'b0000);
      wait_done(1'b0, 1'b1);
      issue(1'b1, 1'b1, 32'h0000_010C, 32'h0000_200C, 32'hA5A5_5A5A, 4'b0100);
      wait_done(1'b1, 1'b1);
      issue(1'b1, 1'b1, 32'h0000_0110, 32'h0000_2010, 32'h0F0F_F0F0, 4'b1000);
      wait_done(1'b1, 1'b1);

      // Reset while the data port is granted, then a late m_ready.
      slave_en = 1'b0;
      m_ready = 1'b0;
      d_addr = 32'h0000_3000; d_wdata = 32'h5555_AAAA; d_wstrb = 4'b1111;
      d_valid = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         if (m_valid) found = 1'b1;
      end
      check("midrst_granted", found, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1; d_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0; m_ready = 1'b1; m_rdata = 32'h0000_CAFE;
      model_last = 1'b0;
      @(negedge clk);
      check("midrst_d_ready", d_ready, 1'b0);
      check("midrst_m_valid", m_valid, 1'b0);
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      @(negedge clk);
      check("midrst_no_spurious", m_valid, 1'b0);
      @(posedge clk);
      #1;
      slave_en = 1'b1;

      // Randomized rounds: fetch only, data only, or both at once.
      for (int r = 0; r < 80; r++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         sel = $urandom_range(0, 2);
         issue(sel != 1, sel != 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
               $urandom, 4'($urandom_range(0, 15)));
         wait_done(sel != 1, sel != 0);
      end

      repeat (5) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_vigna_bus_arbiter
`default_nettype wire

// File: doc/vigna_bus_arbiter.md
Name: vigna_bus_arbiter

Overview:
- Shares one valid/ready memory bus between the core's instruction-fetch port and data port, so a single-ported SRAM or bus slave serves the whole CPU.
- Sits between the core's i_*/d_* ports and the system memory port m_*.
- Runs one transaction at a time. The grant is held from the cycle m_valid rises until the cycle m_ready is seen.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.
- DATA_WIDTH, 32, width of all data buses; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- i_valid  in  1  fetch request from core
- i_ready  out  1  fetch complete; i_rdata valid
- i_addr  in  ADDR_WIDTH  fetch address
- i_rdata  out  DATA_WIDTH  fetched word
- d_valid  in  1  data request from core
- d_ready  out  1  data access complete
- d_addr  in  ADDR_WIDTH  data address
- d_rdata  out  DATA_WIDTH  load data
- d_wdata  in  DATA_WIDTH  store data
- d_wstrb  in  DATA_WIDTH/8  byte strobes; 0 means read
- m_valid  out  1  request to memory (registered)
- m_ready  in  1  memory completion
- m_addr  out  ADDR_WIDTH  muxed address
- m_rdata  in  DATA_WIDTH  memory read data
- m_wdata  out  DATA_WIDTH  muxed write data
- m_wstrb  out  DATA_WIDTH/8  muxed strobes

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, on port reset.
- Reset values: state=IDLE, m_valid=0, grant=NONE, last_grant=I. i_ready=0 and d_ready=0 whenever state is not busy.
- States:
  - IDLE: sample i_valid/d_valid. If neither is set, stay in IDLE.
  - Leaving IDLE: if any is set, pick a winner and go to BUSY_D or BUSY_I; set m_valid=1 at that edge.
  - BUSY_x: m_valid=1. m_addr/m_wdata/m_wstrb driven combinationally from the granted master.
    - For I, m_wdata=0 and m_wstrb=0.
- Completion in BUSY_x when m_ready=1:
  - x_ready=1 combinationally in the same cycle, and x_rdata=m_rdata.
  - At the edge: m_valid<=0, state<=IDLE, last_grant<=x.
- rdata outputs:
  - i_rdata and d_rdata carry m_rdata at all times (no mux needed).
  - Only the granted port's ready is ever asserted.
- Latency: request sampled in cycle N gives m_valid in N+1. With a zero-wait slave, ready is in N+1 and IDLE in N+2. Peak throughput is one transaction per 2 cycles.
- Mandatory IDLE cycle: one IDLE cycle follows every completion. The core drops valid the cycle after ready, so a stale request is never regranted.
- Default priority: d wins over i on simultaneous requests (starvation-free because the core never issues both back-to-back indefinitely).
- Held requests: a request arriving while BUSY stays pending. The requester keeps valid high and its address stable; the arbiter does not latch it.
- m_ready asserted in IDLE: ignored; no ready is forwarded.
- Reset mid-transaction: state returns to IDLE and m_valid goes to 0 on the reset edge. A late m_ready after reset is ignored.
- Master dropping valid while BUSY: protocol violation. The arbiter keeps the grant until m_ready.

Optional Feature:
- Macro: VIGNA_BUS_ARBITER_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the winner is the master other than last_grant. A single requester always wins.
- Undefined: fixed priority, d over i. last_grant register may be removed.

Decomposition:
- Shared package vigna_bus_pkg:
  - state encoding localparams ST_IDLE=2'b00, ST_BUSY_I=2'b01, ST_BUSY_D=2'b10.
  - grant IDs GNT_I=1'b0, GNT_D=1'b1.
  - VIGNA_BUS_STRB_W derived from DATA_WIDTH.
- Optional sub-module vigna_arb_pick: two-request winner select (fixed or round-robin). The FSM and muxes stay in the top module.

Test Plan:
- Reset: hold reset=1 with i_valid=1 for 3 cycles -> m_valid=0, i_ready=0, d_ready=0 throughout. m_valid rises one cycle after reset falls.
- Single fetch:
  - Stimulus: i_valid=1, i_addr=0x0000_0100; slave ready 2 cycles after m_valid; m_rdata=0x0000_0013.
  - Response: m_addr=0x100, m_wstrb=0; i_ready=1 for exactly one cycle; i_rdata=0x13; d_ready stays 0.
- Store pass-through:
  - Stimulus: d_valid=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=4'b0011.
  - Response: m_addr=0x2000, m_wdata=0xDEADBEEF, m_wstrb=0011; d_ready pulses once.
- Simultaneous requests (fixed priority): i_valid and d_valid rise together -> data granted first, fetch granted after one IDLE cycle. Both complete; no ready is duplicated.
- Round-robin (macro defined): two consecutive simultaneous-request rounds with last_grant=D -> first grant I, then D.
- Reset mid-transaction: reset in BUSY_D, then m_ready=1 the next cycle -> d_ready stays 0, state IDLE, no spurious m_valid.
